chess_clock_countdown: RTL and testbench
========================================

# chess_clock_countdown

Per-player countdown core for the chess clock. Holds a two-digit BCD time value, prescales the 50 MHz clock down to one count unit, and decrements while enabled. It reports when time is exhausted and when it is running low. Sits inside the player interface: consumes the preset digits from the init-switch driver and the run/stop decision from the clock FSM, and feeds BCD digits to the seven-segment encoder and the zero flag back to the FSM.

## Interface
- p_divider, 17_865_771: enabled clock cycles per count unit, ≥ 2
- p_warn, 10: low-time threshold, compared as a decimal value 0..99
- i_clk  in  1  system clock (50 MHz)
- i_rst  in  1  synchronous, active-high reset; also acts as game restart
- i_init  in  [3:0] [1:0]  preset BCD; [1] tens, [0] units
- i_load  in  1  single-cycle pulse: reload the preset
- i_run  in  1  level: count enable, driven by this player's turn and not stopped
- o_digit  out  [3:0] [1:0]  current BCD value; [1] tens, [0] units
- o_zero  out  1  value is 00
- o_warn  out  1  value is nonzero and ≤ p_warn
- o_tick  out  1  one-cycle pulse coincident with each decrement

## Operation
- Preset clamp:
  - Each i_init digit > 9 is loaded as 9.
  - Example: preset 4'hC,4'h3 loads 93.
- Reset and load:
  - On a cycle where i_rst or i_load is high, the next edge applies these actions:
    - o_digit ← clamped preset
    - prescaler ← 0
    - o_tick ← 0
  - Priority: i_rst > i_load > counting.
- Enable:
  - en = i_run & ~o_zero & ~i_rst & ~i_load.
  - Prescaler advances only when en is high.
  - When en is low, the prescaler holds its value and is not cleared. Pause/resume therefore loses no partial unit.
- Count:
  - While en is high and prescaler = p_divider−1, the next edge does three things:
    - wraps the prescaler to 0
    - decrements the value
    - sets o_tick to 1 for exactly one cycle
  - Otherwise the prescaler increments by 1.
- BCD decrement:
  - If units > 0: units − 1.
  - Else: units ← 9 and tens ← tens − 1.
  - A decrement from 00 never occurs, because o_zero blocks en.
  - Digits never leave 0..9.
- o_zero and o_warn are combinational decodes of the registered digits. They change in the same cycle as o_digit.
- Saturation:
  - At 00 the block stops counting.
  - The prescaler holds.
  - o_zero stays high until the next reset or load.
- Prescaler width: $clog2(p_divider).
- No other state.

## Timing
- Reset values (cycle after i_rst sampled high):
  - o_digit = clamped i_init
  - o_tick = 0
  - prescaler = 0
  - o_zero and o_warn follow the loaded value
- Time from the start of continuous i_run to the first decrement:
  - From reset or load: exactly p_divider cycles. With i_run high from cycle 0, the new value is visible in cycle p_divider.
  - After a pause: p_divider minus the cycles already accumulated.
- o_tick:
  - high only in the first cycle showing the new value
  - never high in two consecutive cycles, because p_divider ≥ 2
- Load coinciding with a terminal prescaler count:
  - The load wins.
  - No decrement occurs, and o_tick stays 0.
- i_run falling in the terminal cycle:
  - No decrement occurs.
  - The prescaler holds at p_divider−1.
  - The decrement fires on the first cycle i_run returns.
- Preset 00 loaded: o_zero = 1 in the next cycle, and counting never starts.
- i_init changing while not loading: no effect.

## Test plan
- Use p_divider = 4 and p_warn = 10 throughout.
- Reset, preset tens=1, units=2, i_run = 1 continuously:
  - Cycle 1 after reset: 12, o_warn = 0.
  - Cycle 4: 11 with o_tick pulse, o_warn = 0.
  - Cycle 8: 10, o_warn = 1.
  - Cycle 12: 09.
  - Cycle 48: 00, o_zero = 1.
  - After that: no further o_tick, value holds at 00.
- Pause/resume:
  - Preset 05, i_run high 3 cycles, low 10 cycles, high again.
  - Value stays 05 during the pause.
  - 04 appears on the first resumed cycle with an o_tick pulse.
- Clamp: preset 4'hF,4'hA, then load → 99, o_zero = 0, o_warn = 0.
- Priority:
  - i_load asserted in the cycle the prescaler is at 3 with i_run = 1.
  - Result: value returns to the preset, no o_tick, and the next decrement occurs 4 cycles later.
- Borrow: preset 20, run 4 cycles → 19 (units wrap 0→9, tens 2→1).
- Reset mid-count at value 07: after reset, value = preset, o_zero cleared, prescaler restarts, and the first tick is 4 cycles later.

Source files
------------

// File: rtl/chess_clock_countdown.sv
// chess_clock_countdown
// Per-player countdown core for the chess clock. Holds a two-digit BCD time
// value, divides the system clock down to one count unit with a prescaler,
// and decrements the value once per unit while this player's clock runs.
// Reports exhaustion (o_zero), low time (o_warn) and each decrement (o_tick).
//
// Control contract: i_rst outranks i_load, which outranks counting. The
// prescaler only moves while counting is enabled and is never cleared by a
// pause, so a partial unit survives stop/start. Once the value reaches 00
// the count enable drops and everything holds until a reset or a load.

module chess_clock_countdown #(
    parameter int p_divider = 17_865_771,
    parameter int p_warn    = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [1:0][3:0] i_init,
    input  logic            i_load,
    input  logic            i_run,
    output logic [1:0][3:0] o_digit,
    output logic            o_zero,
    output logic            o_warn,
    output logic            o_tick
);

    // Prescaler width; a divider of exactly 2 still needs one bit.
    localparam int PW = (p_divider > 2) ? $clog2(p_divider) : 1;
    localparam logic [PW-1:0] PRESC_TERM = PW'(p_divider - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [6:0]    WARN_VALUE = 7'(p_warn);

    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic [1:0][3:0] digit_q;
    logic [1:0][3:0] digit_d;
    logic            tick_q;
    logic            tick_d;

    logic [1:0][3:0] preset;
    logic [1:0][3:0] digit_dec;
    logic            zero;
    logic            en;
    logic            terminal;
    logic [6:0]      value;

    // A preset digit above 9 is not a BCD digit; treat it as the largest one.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Clamp the preset digits so the held value is always valid BCD.
    always_comb begin
        preset[1] = clamp_bcd(i_init[1]);
        preset[0] = clamp_bcd(i_init[0]);
    end

    // One BCD step down: units borrow from tens when they are already 0.
    always_comb begin
        digit_dec = digit_q;
        if (digit_q[0] != 4'd0) begin
            digit_dec[0] = digit_q[0] - 4'd1;
        end else if (digit_q[1] != 4'd0) begin
            digit_dec[0] = 4'd9;
            digit_dec[1] = digit_q[1] - 4'd1;
        end
    end

    // Status decodes of the registered value, and the count enable.
    always_comb begin
        zero     = (digit_q[1] == 4'd0) && (digit_q[0] == 4'd0);
        value    = (7'(digit_q[1]) * 7'd10) + 7'(digit_q[0]);
        en       = i_run && !zero && !i_rst && !i_load;
        terminal = (presc_q == PRESC_TERM);
    end

    // Next-state selection: load beats counting; a paused prescaler holds.
    always_comb begin
        presc_d = presc_q;
        digit_d = digit_q;
        tick_d  = 1'b0;
        if (i_load) begin
            presc_d = '0;
            digit_d = preset;
        end else if (en) begin
            if (terminal) begin
                presc_d = '0;
                digit_d = digit_dec;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end
    end

    // State registers; reset restarts the game from the preset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q <= '0;
            digit_q <= preset;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            tick_q  <= tick_d;
        end
    end

    assign o_digit = digit_q;
    assign o_zero  = zero;
    assign o_warn  = !zero && (value <= WARN_VALUE);
    assign o_tick  = tick_q;

endmodule

// File: tb/tb_chess_clock_countdown.sv
// Bench for chess_clock_countdown with a small divider. A reference model
// tracks the time as a plain integer (0..99) plus a count of enabled cycles
// since the last unit, queues the expected outputs every clock, and a
// compare process checks the DUT on every falling edge. Directed literal
// checks pin the model at the points worked out by hand.

module tb_chess_clock_countdown;
  localparam int DIV  = 4;
  localparam int WARN = 10;
  localparam int W    = 11;  // {tick, warn, zero, tens[3:0], units[3:0]}

  logic            clk;
  logic            rst;
  logic [1:0][3:0] init;
  logic            load;
  logic            run;
  logic [1:0][3:0] digit;
  logic            zero;
  logic            warn;
  logic            tick;

  int n_checks = 0;
  int n_pass   = 0;

  chess_clock_countdown #(
    .p_divider(DIV),
    .p_warn   (WARN)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_init (init),
    .i_load (load),
    .i_run  (run),
    .o_digit(digit),
    .o_zero (zero),
    .o_warn (warn),
    .o_tick (tick)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  int  m_val   = 0;
  int  m_acc   = 0;
  bit  m_tick  = 0;
  bit  m_valid = 0;
  logic [W-1:0] exp_q[$];

  function automatic int clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [W-1:0] model_outputs();
    logic [3:0] tens;
    logic [3:0] units;
    logic       w;
    logic       z;
    tens  = 4'(m_val / 10);
    units = 4'(m_val % 10);
    z     = (m_val == 0);
    w     = (m_val != 0) && (m_val <= WARN);
    return {m_tick, w, z, tens, units};
  endfunction

  // Model advances on the same edge as the DUT, from the same inputs.
  always @(posedge clk) begin
    if (rst || load) begin
      m_val   = clamp_digit(init[1]) * 10 + clamp_digit(init[0]);
      m_acc   = 0;
      m_tick  = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_tick = 0;
      if (run && m_val > 0) begin
        m_acc++;
        if (m_acc == DIV) begin
          m_acc  = 0;
          m_val  = m_val - 1;
          m_tick = 1;
        end
      end
    end
    if (m_valid) exp_q.push_back(model_outputs());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {tick, warn, zero, digit[1], digit[0]};
      check("cycle_outputs", 32'(g), 32'(e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] tens, input logic [3:0] units, input logic r);
    init = {tens, units};
    load = 1'b1;
    run  = r;
    cycles(1);
    load = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] bcd, input logic t,
                            input logic w, input logic z);
    check({name, "_digits"}, 32'({digit[1], digit[0]}), 32'(bcd));
    check({name, "_tick"}, 32'(tick), 32'(t));
    check({name, "_warn"}, 32'(warn), 32'(w));
    check({name, "_zero"}, 32'(zero), 32'(z));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    load = 1'b0;
    run  = 1'b1;
    init = {4'd1, 4'd2};
    @(negedge clk);
    cycles(1);
    rst = 1'b0;

    // Continuous run from 12.
    expect_out("reset_12", 8'h12, 1'b0, 1'b0, 1'b0);
    cycles(3);
    expect_out("pre_first_tick", 8'h12, 1'b0, 1'b0, 1'b0);
    cycles(1);
    expect_out("first_tick_11", 8'h11, 1'b1, 1'b0, 1'b0);
    init = {4'd7, 4'd7};  // no effect without a load
    cycles(4);
    expect_out("warn_10", 8'h10, 1'b1, 1'b1, 1'b0);
    cycles(4);
    expect_out("borrow_09", 8'h09, 1'b1, 1'b1, 1'b0);
    cycles(36);
    expect_out("reach_00", 8'h00, 1'b1, 1'b0, 1'b1);
    cycles(12);
    expect_out("hold_00", 8'h00, 1'b0, 1'b0, 1'b1);

    // Pause/resume keeps the partial unit.
    do_load(4'd0, 4'd5, 1'b0);
    run = 1'b1;
    cycles(3);
    run = 1'b0;
    cycles(10);
    expect_out("paused_05", 8'h05, 1'b0, 1'b1, 1'b0);
    run = 1'b1;
    cycles(1);
    expect_out("resume_04", 8'h04, 1'b1, 1'b1, 1'b0);

    // Clamp of non-BCD preset digits.
    run = 1'b0;
    do_load(4'hF, 4'hA, 1'b0);
    expect_out("clamp_99", 8'h99, 1'b0, 1'b0, 1'b0);

    // Load at terminal prescaler count wins over the decrement.
    run = 1'b1;
    cycles(3);
    do_load(4'hF, 4'hA, 1'b1);
    expect_out("load_wins", 8'h99, 1'b0, 1'b0, 1'b0);
    cycles(3);
    expect_out("after_load_3", 8'h99, 1'b0, 1'b0, 1'b0);
    cycles(1);
    expect_out("after_load_4", 8'h98, 1'b1, 1'b0, 1'b0);

    // Run dropping in the terminal cycle: decrement fires on return.
    do_load(4'd3, 4'd0, 1'b1);
    cycles(3);
    run = 1'b0;
    cycles(2);
    expect_out("stop_at_term", 8'h30, 1'b0, 1'b0, 1'b0);
    run = 1'b1;
    cycles(1);
    expect_out("term_resume", 8'h29, 1'b1, 1'b0, 1'b0);

    // Tens borrow 20 -> 19.
    do_load(4'd2, 4'd0, 1'b1);
    cycles(4);
    expect_out("borrow_19", 8'h19, 1'b1, 1'b0, 1'b0);

    // Reset mid-count at 07.
    do_load(4'd0, 4'd8, 1'b1);
    cycles(4);
    expect_out("at_07", 8'h07, 1'b1, 1'b1, 1'b0);
    cycles(2);
    init = {4'd1, 4'd5};
    rst  = 1'b1;
    cycles(1);
    rst = 1'b0;
    expect_out("reset_15", 8'h15, 1'b0, 1'b0, 1'b0);
    cycles(3);
    expect_out("reset_pre_tick", 8'h15, 1'b0, 1'b0, 1'b0);
    cycles(1);
    expect_out("reset_tick_14", 8'h14, 1'b1, 1'b0, 1'b0);

    // Preset 00 never counts.
    do_load(4'd0, 4'd0, 1'b1);
    expect_out("preset_00", 8'h00, 1'b0, 1'b0, 1'b1);
    cycles(9);
    expect_out("preset_00_hold", 8'h00, 1'b0, 1'b0, 1'b1);

    // Low-time boundary at 01.
    do_load(4'd0, 4'd1, 1'b0);
    expect_out("warn_01", 8'h01, 1'b0, 1'b1, 1'b0);
    do_load(4'd1, 4'd1, 1'b0);
    expect_out("nowarn_11", 8'h11, 1'b0, 1'b0, 1'b0);

    cycles(2);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
